// File: rtl/phi2_controller_pkg.sv
// Shared encodings for the PHI2 clock controller: mode values and PHI2 levels.
package phi2_controller_pkg;

  typedef enum logic {
    MODE_FREE = 1'b0,
    MODE_STEP = 1'b1
  } mode_e;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

endpackage

// File: rtl/phi2_controller_sync.sv
// Multi-flop synchroniser for the asynchronous stop, go and RESB-sense lines.
module phi2_sync
  import phi2_controller_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = LOW
) (
  input  logic clk,
  input  logic resb,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/phi2_controller.sv
// 6502 PHI2 generator: free-run divider with wait states, GO-driven single step,
// and the CPU reset sequencer that holds RESB for a number of PHI2 cycles.
module phi2_controller
  import phi2_controller_pkg::*;
#(
  parameter int DIV_WIDTH    = 8,
  parameter int DEFAULT_HALF = 6,
  parameter int WAIT_WIDTH   = 4,
  parameter int MIN_HALF     = 2,
  parameter int RESET_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  resb,
  input  logic                  stop,
  input  logic                  go,
  input  logic [WAIT_WIDTH-1:0] wait_states,
  input  logic                  cfg_we,
  input  logic [DIV_WIDTH-1:0]  cfg_data,
  input  logic                  reset_request,
  input  logic                  cpu_resb_sense,
  output logic                  phi2,
  output logic                  phi2_rise,
  output logic                  phi2_fall,
  output logic                  cpu_reset_hold,
  output logic                  step_mode
);

  localparam int CNT_W = ((DIV_WIDTH > WAIT_WIDTH) ? DIV_WIDTH : WAIT_WIDTH) + 2;
  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HALF);

  logic                  stop_s, go_s, sense_s;
  mode_e                 state, state_next;
  logic [DIV_WIDTH-1:0]  half, half_pend, cfg_val;
  logic [WAIT_WIDTH-1:0] wait_q;
  logic [CNT_W-1:0]      cnt, cnt_next, base, limit;
  logic                  toggle, go_pend, trigger;
  logic [RST_W-1:0]      rst_cnt;

  phi2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(HIGH)) u_stop_sync (
    .clk(clk), .resb(resb), .d(stop), .q(stop_s)
  );
  phi2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(LOW)) u_go_sync (
    .clk(clk), .resb(resb), .d(go), .q(go_s)
  );
  phi2_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(HIGH)) u_sense_sync (
    .clk(clk), .resb(resb), .d(cpu_resb_sense), .q(sense_s)
  );

  // cnt_next is the number of clk cycles the current level will have lasted
  // once this cycle ends; it saturates so long step-mode phases cannot wrap.
  always_comb begin
    cfg_val  = (cfg_data == '0) ? DIV_WIDTH'(1) : cfg_data;
    cnt_next = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    base     = (CNT_W'(half) > MIN_C) ? CNT_W'(half) : MIN_C;
    limit    = base;
    if (state == MODE_FREE && phi2 == HIGH) limit = base + CNT_W'(wait_q);
  end

  always_comb begin
    toggle = 1'b0;
    if (state == MODE_FREE) begin
      toggle = (cnt_next >= limit);
    end else begin
      toggle = (cnt_next >= MIN_C) && (go_pend || (go_s != phi2));
    end
  end

  // Mode FSM: state register
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) state <= MODE_FREE;
    else       state <= state_next;
  end

  // Mode FSM: next state; both switches happen only with PHI2 low
  always_comb begin
    state_next = state;
    if (state == MODE_FREE) begin
      if (!stop_s && toggle && phi2 == HIGH) state_next = MODE_STEP;
    end else begin
      if (stop_s && phi2 == LOW && cnt_next >= MIN_C) state_next = MODE_FREE;
    end
  end

  // Mode FSM: outputs
  always_comb begin
    step_mode = (state == MODE_STEP);
  end

  // A write landing on a boundary takes effect for the phase that boundary starts.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      phi2      <= LOW;
      phi2_rise <= 1'b0;
      phi2_fall <= 1'b0;
      cnt       <= '0;
      half      <= DIV_WIDTH'(DEFAULT_HALF);
      half_pend <= DIV_WIDTH'(DEFAULT_HALF);
      wait_q    <= '0;
      go_pend   <= 1'b0;
    end else begin
      phi2_rise <= toggle && (phi2 == LOW);
      phi2_fall <= toggle && (phi2 == HIGH);
      if (cfg_we) half_pend <= cfg_val;
      if (toggle) begin
        phi2 <= ~phi2;
        cnt  <= '0;
        half <= cfg_we ? cfg_val : half_pend;
        if (phi2 == LOW) wait_q <= wait_states;
      end else begin
        cnt <= cnt_next;
      end
      // Remembers a GO change seen before the minimum phase elapsed.
      go_pend <= (state == MODE_STEP) && !toggle && (go_pend || (go_s != phi2));
    end
  end

  always_comb begin
    trigger = reset_request || (!sense_s && !cpu_reset_hold);
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      cpu_reset_hold <= 1'b1;
      rst_cnt        <= '0;
    end else if (trigger) begin
      cpu_reset_hold <= 1'b1;
      rst_cnt        <= '0;
    end else if (cpu_reset_hold && phi2_fall) begin
      rst_cnt <= rst_cnt + RST_W'(1);
      if (rst_cnt == RST_W'(RESET_CYCLES - 1)) cpu_reset_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_phi2_controller.sv
// Bench for phi2_controller: phase-length scoreboard, free-run vector table,
// and directed sequences for step mode, wait states and reset sequencing.
module tb_phi2_controller;

  localparam int MIN_HALF = 2;

  logic       clk;
  logic       resb;
  logic       stop;
  logic       go;
  logic [3:0] wait_states;
  logic       cfg_we;
  logic [7:0] cfg_data;
  logic       reset_request;
  logic       cpu_resb_sense;
  logic       phi2;
  logic       phi2_rise;
  logic       phi2_fall;
  logic       cpu_reset_hold;
  logic       step_mode;

  phi2_controller #(
    .DIV_WIDTH(8), .DEFAULT_HALF(6), .WAIT_WIDTH(4),
    .MIN_HALF(MIN_HALF), .RESET_CYCLES(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .resb(resb),
    .stop(stop),
    .go(go),
    .wait_states(wait_states),
    .cfg_we(cfg_we),
    .cfg_data(cfg_data),
    .reset_request(reset_request),
    .cpu_resb_sense(cpu_resb_sense),
    .phi2(phi2),
    .phi2_rise(phi2_rise),
    .phi2_fall(phi2_fall),
    .cpu_reset_hold(cpu_reset_hold),
    .step_mode(step_mode)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // scoreboard: expected completed phases, {level, length}
  logic [15:0] exp_q[$];

  typedef struct {
    int cfg;
    int ws;
    int hi;
    int lo;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_phase(input logic lvl, input int len);
    exp_q.push_back({lvl, 15'(len)});
  endfunction

  // monitor: strobes every cycle, phase lengths on every PHI2 change
  logic        prev = 1'b0;
  int          run  = 1;
  logic [15:0] got_ph, exp_ph;

  always @(negedge clk) begin
    if (!resb) begin
      prev = 1'b0;
      run  = 1;
    end else begin
      check("rise_strobe", phi2_rise, phi2 & ~prev);
      check("fall_strobe", phi2_fall, ~phi2 & prev);
      if (phi2 != prev) begin
        check("min_phase", (run >= MIN_HALF) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          exp_ph = exp_q.pop_front();
          got_ph = {prev, 15'(run)};
          n_vec++;
          if (got_ph != exp_ph) begin
            n_err++;
            $display("FAIL phase: got level %0d len %0d, expected level %0d len %0d at %0t",
                     prev, run, exp_ph[15], exp_ph[14:0], $time);
          end
        end
        prev = phi2;
        run  = 1;
      end else begin
        run++;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input string name, input int budget);
    int i = 0;
    while (!phi2_rise && i < budget) begin
      tick();
      i++;
    end
    check(name, phi2_rise, 1);
  endtask

  task automatic wait_fall(input string name, input int budget);
    int i = 0;
    while (!phi2_fall && i < budget) begin
      tick();
      i++;
    end
    check(name, phi2_fall, 1);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      tick();
      i++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic count_falls(input string name, input int n, input int budget);
    int falls = 0;
    int i = 0;
    while (falls < n && i < budget) begin
      tick();
      if (phi2_fall) falls++;
      i++;
    end
    check(name, falls, n);
  endtask

  task automatic wait_hold_release(input string name, input int exp_falls, input int budget);
    int   falls = 0;
    logic last_fall = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!cpu_reset_hold) begin
        done = 1'b1;
      end else begin
        if (phi2_fall) falls++;
        last_fall = phi2_fall;
      end
    end
    check({name, "_released"}, done, 1);
    check({name, "_falls"}, falls, exp_falls);
    check({name, "_after_fall"}, last_fall, 1);
  endtask

  task automatic write_cfg(input int value);
    cfg_we   = 1'b1;
    cfg_data = 8'(value);
    tick();
    cfg_we   = 1'b0;
  endtask

  int prev_hi;

  initial begin
    tbl[0] = '{6, 0, 6, 6};
    tbl[1] = '{3, 0, 3, 3};
    tbl[2] = '{0, 0, 2, 2};
    tbl[3] = '{1, 2, 4, 2};
    tbl[4] = '{4, 3, 7, 4};
    tbl[5] = '{2, 15, 17, 2};
    tbl[6] = '{10, 0, 10, 10};
    tbl[7] = '{6, 0, 6, 6};

    resb = 1'b0; stop = 1'b1; go = 1'b0; wait_states = '0;
    cfg_we = 1'b0; cfg_data = '0; reset_request = 1'b0; cpu_resb_sense = 1'b1;

    // reset values, then power-on reset sequence
    repeat (3) tick();
    check("rst_phi2", phi2, 0);
    check("rst_rise", phi2_rise, 0);
    check("rst_fall", phi2_fall, 0);
    check("rst_hold", cpu_reset_hold, 1);
    check("rst_step", step_mode, 0);
    @(negedge clk);
    #1 resb = 1'b1;
    push_phase(1'b0, 6); push_phase(1'b1, 6);
    push_phase(1'b0, 6); push_phase(1'b1, 6);
    wait_hold_release("por", 8, 200);
    wait_empty("por_q", 50);

    // free-run table: write half (and wait states) just after a rise
    prev_hi = 6;
    for (int i = 0; i < 8; i++) begin
      wait_rise("tbl_rise", 60);
      cfg_we = 1'b1;
      cfg_data = 8'(tbl[i].cfg);
      wait_states = 4'(tbl[i].ws);
      push_phase(1'b1, prev_hi);
      push_phase(1'b0, tbl[i].lo);
      tick();
      cfg_we = 1'b0;
      wait_empty("tbl_q", 80);
      prev_hi = tbl[i].hi;
    end

    // wait states latched at the rise, later change ignored
    wait_rise("ws_rise", 60);
    wait_states = 4'd4;
    push_phase(1'b1, 6); push_phase(1'b0, 6);
    wait_empty("ws_q0", 40);
    push_phase(1'b1, 10); push_phase(1'b0, 6); push_phase(1'b1, 6);
    wait_states = 4'd0;
    wait_empty("ws_q1", 60);

    // back-to-back writes: last one wins
    wait_rise("b2b_rise", 60);
    push_phase(1'b1, 6); push_phase(1'b0, 4); push_phase(1'b1, 4);
    cfg_we = 1'b1; cfg_data = 8'd9;
    tick();
    cfg_data = 8'd4;
    tick();
    cfg_we = 1'b0;
    wait_empty("b2b_q", 60);
    wait_rise("b2b_rise2", 60);
    push_phase(1'b1, 4); push_phase(1'b0, 6);
    write_cfg(6);
    wait_empty("b2b_q2", 60);

    // write coinciding with a boundary: old half ends it, new half follows
    wait_rise("bnd_rise", 60);
    push_phase(1'b1, 6); push_phase(1'b0, 3); push_phase(1'b1, 3);
    repeat (5) tick();
    write_cfg(3);
    wait_empty("bnd_q", 60);
    wait_rise("bnd_rise2", 60);
    push_phase(1'b1, 3); push_phase(1'b0, 6);
    write_cfg(6);
    wait_empty("bnd_q2", 60);

    // free -> step while high, 1-clk go pulse, step -> free after 1 clk of low
    wait_rise("step_rise", 60);
    stop = 1'b0;
    push_phase(1'b1, 6);
    wait_fall("step_fall", 40);
    check("step_entered", step_mode, 1);
    push_phase(1'b0, 13); push_phase(1'b1, 2);
    repeat (10) tick();
    check("step_hold_low", phi2, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_fall("go_fall", 40);
    check("step_after_go", step_mode, 1);
    stop = 1'b1;
    push_phase(1'b0, 6); push_phase(1'b1, 6);
    wait_empty("step_q", 60);
    check("step_left", step_mode, 0);

    // RESB sense low with hold released
    wait_rise("sense_rise", 60);
    check("sense_pre_hold", cpu_reset_hold, 0);
    cpu_resb_sense = 1'b0;
    repeat (3) tick();
    cpu_resb_sense = 1'b1;
    check("sense_hold", cpu_reset_hold, 1);
    wait_hold_release("sense", 8, 200);

    // reset_request during the hold restarts the count
    wait_rise("req_rise", 60);
    reset_request = 1'b1;
    tick();
    reset_request = 1'b0;
    check("req_hold", cpu_reset_hold, 1);
    count_falls("req_three_falls", 3, 60);
    wait_rise("req_rise2", 60);
    check("req_hold_mid", cpu_reset_hold, 1);
    reset_request = 1'b1;
    tick();
    reset_request = 1'b0;
    wait_hold_release("restart", 8, 200);

    // async reset mid-high with a pending half write
    wait_rise("ar_rise", 60);
    write_cfg(3);
    check("ar_pre_phi2", phi2, 1);
    #2 resb = 1'b0;
    #1;
    check("ar_phi2", phi2, 0);
    check("ar_rise", phi2_rise, 0);
    check("ar_fall", phi2_fall, 0);
    check("ar_hold", cpu_reset_hold, 1);
    check("ar_step", step_mode, 0);
    repeat (2) tick();
    @(negedge clk);
    #1 resb = 1'b1;
    push_phase(1'b0, 6); push_phase(1'b1, 6);
    wait_hold_release("ar_seq", 8, 200);
    wait_empty("ar_q", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
